// File: rtl/execute_alu_pkg.sv
// Shared definitions for the execute-stage ALU: opcodes, condition codes,
// NZCV bit positions and the pipeline-register state encoding.
package execute_alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'h0,
    OP_EOR = 4'h1,
    OP_SUB = 4'h2,
    OP_RSB = 4'h3,
    OP_ADD = 4'h4,
    OP_ADC = 4'h5,
    OP_SBC = 4'h6,
    OP_RSC = 4'h7,
    OP_TST = 4'h8,
    OP_TEQ = 4'h9,
    OP_CMP = 4'hA,
    OP_CMN = 4'hB,
    OP_ORR = 4'hC,
    OP_MOV = 4'hD,
    OP_BIC = 4'hE,
    OP_MVN = 4'hF
  } alu_op_e;

  typedef enum logic [3:0] {
    CC_EQ = 4'h0,
    CC_NE = 4'h1,
    CC_CS = 4'h2,
    CC_CC = 4'h3,
    CC_MI = 4'h4,
    CC_PL = 4'h5,
    CC_VS = 4'h6,
    CC_VC = 4'h7,
    CC_HI = 4'h8,
    CC_LS = 4'h9,
    CC_GE = 4'hA,
    CC_LT = 4'hB,
    CC_GT = 4'hC,
    CC_LE = 4'hD,
    CC_AL = 4'hE,
    CC_NV = 4'hF
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/execute_alu_cond_check.sv
// Combinational ARM condition evaluation against an NZCV value.
module cond_check
  import execute_alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  // NOTE: pass gets a default before the case so no path can leave it unassigned (no latch).
  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      CC_EQ:   pass = z;
      CC_NE:   pass = !z;
      CC_CS:   pass = c;
      CC_CC:   pass = !c;
      CC_MI:   pass = n;
      CC_PL:   pass = !n;
      CC_VS:   pass = v;
      CC_VC:   pass = !v;
      CC_HI:   pass = c && !z;
      CC_LS:   pass = !c || z;
      CC_GE:   pass = (n == v);
      CC_LT:   pass = (n != v);
      CC_GT:   pass = !z && (n == v);
      CC_LE:   pass = z || (n != v);
      CC_AL:   pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_alu.sv
// Execute stage: ARM data-processing ALU with a one-entry valid/ready
// output register and the committed NZCV flags register.
module execute_alu
  import execute_alu_pkg::*;
#(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  cond,
  input  logic [3:0]  aluOp,
  input  logic        setFlags,
  input  logic [31:0] rnData,
  input  logic [31:0] op2Data,
  input  logic        shiftCarry,
  input  logic [3:0]  rdAddr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  out_rdAddr,
  output logic        writeEnable,
  output logic [3:0]  flags
);

  state_e      state_q, state_d;
  alu_op_e     op;
  logic        xfer;
  logic        cond_pass;
  logic        is_compare;
  logic        is_arith;
  logic [31:0] add_a, add_b;
  logic        add_cin;
  logic [32:0] sum;
  logic [31:0] logic_res;
  logic [31:0] alu_res;
  logic [3:0]  nzcv_next;
  logic        flags_we;

  assign op        = alu_op_e'(aluOp);
  assign out_valid = (state_q == ST_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign xfer      = in_valid && in_ready;

  assign is_compare = op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN};
  assign is_arith   = op inside {OP_SUB, OP_RSB, OP_ADD, OP_ADC,
                                 OP_SBC, OP_RSC, OP_CMP, OP_CMN};

  cond_check u_cond_check (
    .cond (cond),
    .nzcv (flags),
    .pass (cond_pass)
  );

  // Subtraction is a + ~b + carry-in; reverse forms swap which operand is inverted.
  always_comb begin
    add_a   = rnData;
    add_b   = op2Data;
    add_cin = 1'b0;
    case (op)
      OP_ADD, OP_CMN: begin
        add_a = rnData;  add_b = op2Data;  add_cin = 1'b0;
      end
      OP_ADC: begin
        add_a = rnData;  add_b = op2Data;  add_cin = flags[FLAG_C];
      end
      OP_SUB, OP_CMP: begin
        add_a = rnData;  add_b = ~op2Data; add_cin = 1'b1;
      end
      OP_SBC: begin
        add_a = rnData;  add_b = ~op2Data; add_cin = flags[FLAG_C];
      end
      OP_RSB: begin
        add_a = op2Data; add_b = ~rnData;  add_cin = 1'b1;
      end
      OP_RSC: begin
        add_a = op2Data; add_b = ~rnData;  add_cin = flags[FLAG_C];
      end
      default: begin
        add_a = rnData;  add_b = op2Data;  add_cin = 1'b0;
      end
    endcase
  end

  assign sum = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  always_comb begin
    logic_res = 32'd0;
    case (op)
      OP_AND, OP_TST: logic_res = rnData & op2Data;
      OP_EOR, OP_TEQ: logic_res = rnData ^ op2Data;
      OP_ORR:         logic_res = rnData | op2Data;
      OP_MOV:         logic_res = op2Data;
      OP_BIC:         logic_res = rnData & ~op2Data;
      OP_MVN:         logic_res = ~op2Data;
      default:        logic_res = 32'd0;
    endcase
  end

  assign alu_res = is_arith ? sum[31:0] : logic_res;

  always_comb begin
    nzcv_next         = flags;
    nzcv_next[FLAG_N] = alu_res[31];
    nzcv_next[FLAG_Z] = (alu_res == 32'd0);
    if (is_arith) begin
      nzcv_next[FLAG_C] = sum[32];
      nzcv_next[FLAG_V] = (add_a[31] == add_b[31]) && (sum[31] != add_a[31]);
    end else begin
      nzcv_next[FLAG_C] = shiftCarry;
    end
  end

  assign flags_we = xfer && cond_pass && (setFlags || is_compare);

  // A simultaneous drain and load keeps the register FULL with no bubble.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (xfer) state_d = ST_FULL;
      ST_FULL:  if (out_ready && !xfer) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      result      <= 32'd0;
      out_rdAddr  <= 4'd0;
      writeEnable <= 1'b0;
      flags       <= FLAG_RESET;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        result      <= alu_res;
        out_rdAddr  <= rdAddr;
        writeEnable <= cond_pass && !is_compare;
      end
      if (flags_we) flags <= nzcv_next;
    end
  end

endmodule

// File: tb/tb_execute_alu.sv
// Directed-vector bench for execute_alu: arithmetic/logical flags,
// conditional execution, back-pressure and asynchronous reset.
module tb_execute_alu;
  import execute_alu_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  cond;
  logic [3:0]  aluOp;
  logic        setFlags;
  logic [31:0] rnData;
  logic [31:0] op2Data;
  logic        shiftCarry;
  logic [3:0]  rdAddr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  out_rdAddr;
  logic        writeEnable;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;

  execute_alu dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .cond        (cond),
    .aluOp       (aluOp),
    .setFlags    (setFlags),
    .rnData      (rnData),
    .op2Data     (op2Data),
    .shiftCarry  (shiftCarry),
    .rdAddr      (rdAddr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .out_rdAddr  (out_rdAddr),
    .writeEnable (writeEnable),
    .flags       (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input alu_op_e op, input cond_e cc, input logic s,
                       input logic [31:0] rn, input logic [31:0] op2,
                       input logic sc, input logic [3:0] rd);
    in_valid   = 1'b1;
    aluOp      = op;
    cond       = cc;
    setFlags   = s;
    rnData     = rn;
    op2Data    = op2;
    shiftCarry = sc;
    rdAddr     = rd;
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cond = CC_AL; aluOp = OP_MOV; setFlags = 1'b0;
    rnData = 32'd0; op2Data = 32'd0; shiftCarry = 1'b0; rdAddr = 4'd0;
    step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {28'd0, flags}, 32'h0);
    check("rst_we", {31'd0, writeEnable}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b1;
    step();

    // ADDS wrap-around
    drive(OP_ADD, CC_AL, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 4'd3);
    step();
    check("adds_valid", {31'd0, out_valid}, 32'd1);
    check("adds_result", result, 32'h0);
    check("adds_flags", {28'd0, flags}, 32'h6);
    check("adds_we", {31'd0, writeEnable}, 32'd1);
    check("adds_rd", {28'd0, out_rdAddr}, 32'd3);

    // SUBS signed overflow
    drive(OP_SUB, CC_AL, 1'b1, 32'h8000_0000, 32'h1, 1'b0, 4'd4);
    step();
    check("subs_result", result, 32'h7FFF_FFFF);
    check("subs_flags", {28'd0, flags}, 32'h3);

    // ANDS: C from shifter, V kept from SUBS
    drive(OP_AND, CC_AL, 1'b1, 32'hF0, 32'h0F, 1'b1, 4'd5);
    step();
    check("ands_result", result, 32'h0);
    check("ands_flags", {28'd0, flags}, 32'h7);

    // RSBS 10 - 3
    drive(OP_RSB, CC_AL, 1'b1, 32'd3, 32'd10, 1'b0, 4'd6);
    step();
    check("rsbs_result", result, 32'd7);
    check("rsbs_flags", {28'd0, flags}, 32'h2);

    // ADCS 1 + 2 + C(1)
    drive(OP_ADC, CC_AL, 1'b1, 32'd1, 32'd2, 1'b0, 4'd7);
    step();
    check("adcs_result", result, 32'd4);
    check("adcs_flags", {28'd0, flags}, 32'h0);

    // Condition NV: transfers but no write-back, no flag update
    drive(OP_ADD, CC_NV, 1'b1, 32'd0, 32'd0, 1'b0, 4'd8);
    step();
    check("nv_valid", {31'd0, out_valid}, 32'd1);
    check("nv_we", {31'd0, writeEnable}, 32'd0);
    check("nv_flags", {28'd0, flags}, 32'h0);

    // CMP 5,5 then MOVEQ / MOVNE
    drive(OP_CMP, CC_AL, 1'b0, 32'd5, 32'd5, 1'b0, 4'd1);
    step();
    check("cmp_we", {31'd0, writeEnable}, 32'd0);
    check("cmp_flags", {28'd0, flags}, 32'h6);
    drive(OP_MOV, CC_EQ, 1'b0, 32'd0, 32'h12, 1'b0, 4'd2);
    step();
    check("moveq_we", {31'd0, writeEnable}, 32'd1);
    check("moveq_result", result, 32'h12);
    drive(OP_MOV, CC_NE, 1'b0, 32'd0, 32'h34, 1'b0, 4'd2);
    step();
    check("movne_we", {31'd0, writeEnable}, 32'd0);
    check("movne_flags", {28'd0, flags}, 32'h6);

    // Idle cycle drains the register
    in_valid = 1'b0;
    step();
    check("idle_valid", {31'd0, out_valid}, 32'd0);
    check("idle_flags", {28'd0, flags}, 32'h6);

    // Back-pressure
    out_ready = 1'b0;
    drive(OP_MOV, CC_AL, 1'b0, 32'd0, 32'hAA, 1'b0, 4'd1);
    step();
    check("bp_a_valid", {31'd0, out_valid}, 32'd1);
    check("bp_a_result", result, 32'hAA);
    drive(OP_MOV, CC_AL, 1'b1, 32'd0, 32'h8000_0000, 1'b0, 4'd2);
    for (int i = 0; i < 2; i++) begin
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      check("bp_hold_result", result, 32'hAA);
      check("bp_hold_rd", {28'd0, out_rdAddr}, 32'd1);
      check("bp_hold_flags", {28'd0, flags}, 32'h6);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("bp_b_valid", {31'd0, out_valid}, 32'd1);
    check("bp_b_result", result, 32'h8000_0000);
    check("bp_b_rd", {28'd0, out_rdAddr}, 32'd2);
    check("bp_b_flags", {28'd0, flags}, 32'h8);

    // Asynchronous reset while FULL, with an instruction still offered
    out_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_flags", {28'd0, flags}, 32'h0);
    check("arst_result", result, 32'h0);
    check("arst_we", {31'd0, writeEnable}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("arst_no_xfer", {31'd0, out_valid}, 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    step();
    check("arst_idle_valid", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_alu.md
EXECUTE_ALU -- requirements
Module: execute_alu

Interface
REQ-001 Parameter: FLAG_RESET, default 4'b0000, NZCV value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream operand-2 stage presents an instruction.
REQ-005 in_ready  output  1  block accepts the instruction this cycle.
REQ-006 cond  input  4  ARM condition field.
REQ-007 aluOp  input  4  ARM data-processing opcode (AND..MVN).
REQ-008 setFlags  input  1  S bit.
REQ-009 rnData  input  32  first operand.
REQ-010 op2Data  input  32  shifted/rotated second operand from the shifter stage.
REQ-011 shiftCarry  input  1  shifter carry-out.
REQ-012 rdAddr  input  4  destination register.
REQ-013 out_valid  output  1  result register holds an instruction.
REQ-014 out_ready  input  1  downstream write-back accepts.
REQ-015 result  output  32  registered ALU result.
REQ-016 out_rdAddr  output  4  registered destination.
REQ-017 writeEnable  output  1  registered: condition passed and opcode is not TST/TEQ/CMP/CMN.
REQ-018 flags  output  4  committed NZCV register, N in bit 3.

Function
REQ-019 Handshake: transfer on in_valid&&in_ready; in_ready = !out_valid || out_ready (one-entry pipeline register, combinational pass-through of ready only).
REQ-020 FSM two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-021 EMPTY->FULL on input transfer; FULL->EMPTY on out_ready without input transfer; FULL->FULL when both occur simultaneously (register reloads, no bubble).
REQ-022 Output fields stay stable while out_valid && !out_ready.
REQ-023 Latency: one cycle from input transfer to out_valid.
REQ-024 Condition evaluated combinationally against the committed flags register at transfer time, all 16 ARM codes; 4'b1111 treated as never.
REQ-025 Arithmetic: 33-bit sum; ADD=Rn+Op2, ADC adds C, SUB=Rn+~Op2+1, SBC=Rn+~Op2+C, RSB/RSC swap operands; CMP as SUB, CMN as ADD.
REQ-026 Arithmetic ops: C = bit 32 of sum; V = operand signs equal and result sign differs (signs taken after inversion).
REQ-027 Logical ops (AND,EOR,TST,TEQ,ORR,MOV,BIC,MVN): C = shiftCarry, V unchanged.
REQ-028 N = result[31], Z = (result==0) for all opcodes.
REQ-029 Flags register updates at the input transfer edge only if condition passes and (setFlags or opcode in TST/TEQ/CMP/CMN); next accepted instruction sees new flags.
REQ-030 Failed condition: instruction still transfers, out_valid asserts, writeEnable=0, flags unchanged.
REQ-031 Wrap-around: 32-bit result truncates; 0xFFFFFFFF+1 gives 0, Z=1, C=1.
REQ-032 No input transfer while in_valid=0; flags never change in that cycle.

Reset
REQ-033 reset low asynchronously forces state EMPTY, out_valid=0, result=0, out_rdAddr=0, writeEnable=0, flags=FLAG_RESET.
REQ-034 Reset mid-operation discards the held instruction; no write-back issued; in_ready=1 after deassertion.
REQ-035 Reset deassertion takes effect on next rising edge; no transfer on that edge if reset was low.

Structure
REQ-036 Shared package holds opcode constants (16 names), condition-code constants, NZCV bit indices, EMPTY/FULL state encoding.
REQ-037 One sub-module, cond_check: combinational cond+NZCV -> pass.
REQ-038 ALU datapath and pipeline register stay in execute_alu.

Verification
REQ-039 ADD, Rn=0xFFFFFFFF, Op2=1, S=1, cond=AL -> next cycle result=0, flags=0110 (Z,C), writeEnable=1.
REQ-040 SUB S=1, Rn=0x80000000, Op2=1 -> result=0x7FFFFFFF, flags=0011 (C,V).
REQ-041 CMP 5,5 then MOVEQ Op2=0x12 cond=EQ -> CMP writeEnable=0 flags=0110; MOV writeEnable=1 result=0x12; MOVNE instead -> writeEnable=0.
REQ-042 ANDS Rn=0xF0, Op2=0x0F, shiftCarry=1 -> result=0, flags N=0 Z=1 C=1 V unchanged.
REQ-043 Back-pressure: out_ready=0 two cycles with in_valid=1 -> in_ready=0, outputs held; out_ready=1 with new input -> simultaneous drain/load, out_valid stays 1.
REQ-044 reset pulsed low while FULL -> out_valid=0, flags=0000 immediately, no transfer on deassertion edge.
